// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch-stage defaults and the {pc, instr} entry handed to decode.
package fetch_unit_pkg;

    localparam int          FU_WIDTH    = 32;
    localparam logic [31:0] FU_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [FU_WIDTH-1:0] pc;
        logic [FU_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry synchronous FIFO; slot 0 is always the head, slot 1 the tail.
module fetch_buffer #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_head,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_slot0;
    logic [W-1:0] r_slot1;
    logic [1:0]   r_count;

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_count <= 2'd0;
        end else begin
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
            // On pop the tail shifts into the head; with a single entry the incoming word becomes the head.
            if (i_pop) begin
                r_slot0 <= (r_count == 2'd2) ? r_slot1 : i_data;
                if (i_push)
                    r_slot1 <= i_data;
            end else if (i_push) begin
                if (r_count == 2'd0)
                    r_slot0 <= i_data;
                else
                    r_slot1 <= i_data;
            end
        end
    end

    assign o_head  = r_slot0;
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, instruction-memory issue, in-flight tracking and redirect in front of a 2-entry
// buffer feeding decode over valid/ready.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int             WIDTH    = FU_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(FU_RESET_PC)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_pc_enable,
    input  logic             i_pc_src,
    input  logic [WIDTH-1:0] i_branch_target,
    output logic             o_imem_en,
    output logic [WIDTH-1:0] o_imem_addr,
    input  logic [WIDTH-1:0] i_imem_rdata,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_pc,
    output logic [WIDTH-1:0] o_out_pc_plus4,
    output logic [WIDTH-1:0] o_out_instr
);

    logic [WIDTH-1:0]   r_pc;
    logic [WIDTH-1:0]   r_inflight_pc;
    logic               r_inflight;
    logic               r_drop;
    logic [1:0]         w_count;
    logic [2*WIDTH-1:0] w_head;
    logic [2:0]         w_occ;
    logic               w_pop;
    logic               w_issue;
    logic               w_push;

    assign w_pop   = o_out_valid & i_out_ready;
    assign w_occ   = {1'b0, w_count} + {2'b00, r_inflight};
    // Never issue unless the response is guaranteed a free slot when it returns.
    assign w_issue = rst_n & i_pc_enable & ~i_pc_src & (w_occ < 3'd2 + {2'b00, w_pop});
    assign w_push  = r_inflight & ~r_drop & ~i_pc_src;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_inflight_pc <= RESET_PC;
            r_inflight    <= 1'b0;
            r_drop        <= 1'b0;
        end else if (i_pc_src) begin
            r_pc       <= i_branch_target;
            r_inflight <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_pc;
                r_pc          <= r_pc + WIDTH'(4);
            end
        end
    end

    fetch_buffer #(.W(2*WIDTH)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop & ~i_pc_src),
        .i_flush (i_pc_src),
        .i_data  ({r_inflight_pc, i_imem_rdata}),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign o_imem_en      = w_issue;
    assign o_imem_addr    = r_pc;
    assign o_out_valid    = w_count != 2'd0;
    assign o_out_pc       = w_head[2*WIDTH-1:WIDTH];
    assign o_out_instr    = w_head[WIDTH-1:0];
    assign o_out_pc_plus4 = o_out_pc + WIDTH'(4);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench; issued PCs are queued from a local PC model and matched against
// every accepted decode output, with directed timing checks around reset, stall, redirect and hold.
module tb_fetch_unit;

    localparam logic [31:0] K = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_enable, pc_src, out_ready;
    logic [31:0] branch_target;
    logic        imem_en, out_valid;
    logic [31:0] imem_addr, imem_rdata, out_pc, out_pc_plus4, out_instr;
    logic        w_en, w_valid;
    logic [31:0] w_addr, w_rdata, w_pc, w_pc4, w_instr;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_pc = 32'h0;
    logic [31:0] held_pc;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .i_pc_enable(pc_enable), .i_pc_src(pc_src),
        .i_branch_target(branch_target), .o_imem_en(imem_en), .o_imem_addr(imem_addr),
        .i_imem_rdata(imem_rdata), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_pc(out_pc), .o_out_pc_plus4(out_pc_plus4), .o_out_instr(out_instr)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .i_pc_enable(pc_enable), .i_pc_src(pc_src),
        .i_branch_target(branch_target), .o_imem_en(w_en), .o_imem_addr(w_addr),
        .i_imem_rdata(w_rdata), .o_out_valid(w_valid), .i_out_ready(out_ready),
        .o_out_pc(w_pc), .o_out_pc_plus4(w_pc4), .o_out_instr(w_instr)
    );

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= imem_addr ^ K;
        if (w_en)    w_rdata    <= w_addr ^ K;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_en", imem_en, 0);
            q.delete();
            model_pc = 32'h0;
        end else if (pc_src) begin
            check("redir_en", imem_en, 0);
            q.delete();
            model_pc = branch_target;
        end else begin
            if (out_valid && out_ready) begin
                check("q_nonempty", q.size() != 0, 1);
                if (q.size() != 0) begin
                    logic [31:0] e;
                    e = q.pop_front();
                    check("out_pc", out_pc, e);
                    check("out_instr", out_instr, e ^ K);
                    check("out_pc_plus4", out_pc_plus4, e + 32'd4);
                end
            end
            if (imem_en) begin
                check("imem_addr", imem_addr, model_pc);
                q.push_back(model_pc);
                model_pc = model_pc + 32'd4;
            end
        end
    end

    initial begin
        rst_n = 1'b0; pc_enable = 1'b1; pc_src = 1'b0; out_ready = 1'b1; branch_target = '0;
        repeat (3) tick();
        sample();
        check("rst_valid", out_valid, 0);
        tick(); rst_n = 1'b1;
        sample();
        check("c0_en", imem_en, 1);
        check("c0_addr", imem_addr, 32'h0);
        check("c0_valid", out_valid, 0);
        check("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        tick(); sample();
        check("c1_valid", out_valid, 0);
        check("c1_addr", imem_addr, 32'h4);
        check("wrap_addr1", w_addr, 32'h0);
        tick(); sample();
        check("c2_valid", out_valid, 1);
        check("c2_pc", out_pc, 32'h0);
        check("wrap_pc", w_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", w_pc4, 32'h0);
        tick(); out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample();
            check("bp_en", imem_en, 0);
            check("bp_valid", out_valid, 1);
            tick();
        end
        out_ready = 1'b1;
        repeat (4) begin sample(); tick(); end
        pc_src = 1'b1; branch_target = 32'h100;
        sample();
        tick(); pc_src = 1'b0;
        sample();
        check("r1_en", imem_en, 1);
        check("r1_addr", imem_addr, 32'h100);
        check("r1_valid", out_valid, 0);
        tick(); sample();
        check("r2_valid", out_valid, 0);
        tick(); sample();
        check("r3_valid", out_valid, 1);
        check("r3_pc", out_pc, 32'h100);
        tick(); pc_src = 1'b1; branch_target = 32'h200;
        sample();
        tick(); branch_target = 32'h300;
        sample();
        tick(); pc_src = 1'b0;
        sample();
        check("rr_addr", imem_addr, 32'h300);
        tick(); sample();
        tick(); sample();
        check("rr_pc", out_pc, 32'h300);
        tick(); pc_enable = 1'b0; held_pc = model_pc;
        for (int i = 0; i < 4; i++) begin
            sample();
            check("hold_en", imem_en, 0);
            check("hold_addr", imem_addr, held_pc);
            if (i == 3) check("hold_drained", out_valid, 0);
            tick();
        end
        pc_enable = 1'b1;
        sample();
        check("resume_en", imem_en, 1);
        check("resume_addr", imem_addr, held_pc);
        repeat (3) begin tick(); sample(); end
        tick(); out_ready = 1'b0;
        sample();
        tick(); sample();
        tick(); sample();
        check("full_valid", out_valid, 1);
        check("full_en", imem_en, 0);
        tick(); rst_n = 1'b0;
        sample();
        tick(); rst_n = 1'b1; out_ready = 1'b1;
        sample();
        check("mrst_valid", out_valid, 0);
        check("mrst_en", imem_en, 1);
        check("mrst_addr", imem_addr, 32'h0);
        repeat (6) begin tick(); sample(); end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
